// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM state type, initial hash values, round
// constants and the compression-function helper functions.
package sha256_pkg;

  typedef enum logic [1:0] {LOAD, ROUND, FINAL, SHIFT_OUT} state_t;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 round: working variables {a..h} packed MSB-first
// (a in [255:224]), plus the round's schedule word and constant.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] vars_i,
  input  logic [31:0]  w_i,
  input  logic [31:0]  k_i,
  output logic [255:0] vars_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = vars_i;
  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = big_sigma0(a) + maj(a, b, c);
  assign vars_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_serial_engine.sv
// Serial SHA-256 engine: narrow beat load, 64-cycle compression, digest shift-out.
// Optional SHA-224 support is compiled in with macro SHA256_SERIAL_SHA224_EN.
module sha256_serial_engine
  import sha256_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic             first_blk,
  input  logic             last_blk,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  input  logic             mode224
);

  localparam logic [8:0] IN_LAST     = 9'(512 / IN_W - 1);
  localparam logic [8:0] OUT_LAST256 = 9'(256 / OUT_W - 1);
  localparam logic [8:0] OUT_W9      = 9'(OUT_W);

  state_t       state_q, state_d;
  logic [8:0]   cnt_q, cnt_d;
  logic [511:0] blk_q, blk_d;
  logic [255:0] h_q, h_d, v_q, v_d, v_rnd, iv_sel;
  logic         last_q, last_d;
  logic         in_fire, out_fire, in_last, rnd_last, out_last;
  logic [31:0]  w_new;
  logic [7:0]   out_idx, out_msb;

  // One counter serves as beat index in LOAD, round index in ROUND and digest
  // beat index in SHIFT_OUT; every exit from those states returns it to zero.
  assign in_fire  = ena & in_valid & in_ready;
  assign out_fire = ena & out_valid & out_ready;
  assign in_last  = (cnt_q == IN_LAST);
  assign rnd_last = (cnt_q == 9'd63);

`ifdef SHA256_SERIAL_SHA224_EN
  localparam logic [8:0] OUT_LAST224 = 9'(224 / OUT_W - 1);
  logic mode_q, mode_d;

  assign iv_sel   = mode224 ? IV224 : IV256;
  assign out_last = (cnt_q == (mode_q ? OUT_LAST224 : OUT_LAST256));
  assign mode_d   = (in_fire && in_last && first_blk) ? mode224 : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode224;
  assign iv_sel      = IV256;
  assign out_last    = (cnt_q == OUT_LAST256);
`endif

  // Sliding 16-word schedule lives in the block register, W[t] in the top word.
  assign w_new = small_sigma1(blk_q[63:32]) + blk_q[223:192]
               + small_sigma0(blk_q[479:448]) + blk_q[511:480];

  sha256_round u_round (
    .vars_i (v_q),
    .w_i    (blk_q[511:480]),
    .k_i    (K[cnt_q[5:0]]),
    .vars_o (v_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:      if (in_fire && in_last) state_d = ROUND;
      ROUND:     if (ena && rnd_last) state_d = FINAL;
      FINAL:     if (ena) state_d = last_q ? SHIFT_OUT : LOAD;
      SHIFT_OUT: if (out_fire && out_last) state_d = LOAD;
      default:   state_d = LOAD;
    endcase
  end

  assign out_idx = 8'(cnt_q * OUT_W9);
  assign out_msb = 8'd255 - out_idx;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        busy     = (cnt_q != '0);
      end
      SHIFT_OUT: begin
        out_valid = 1'b1;
        out_data  = h_q[out_msb -: OUT_W];
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    blk_d  = blk_q;
    h_d    = h_q;
    v_d    = v_q;
    last_d = last_q;
    if (ena) begin
      case (state_q)
        LOAD: if (in_fire) begin
          blk_d = {blk_q[511-IN_W:0], in_data};
          cnt_d = in_last ? '0 : cnt_q + 9'd1;
          if (in_last) begin
            last_d = last_blk;
            h_d    = first_blk ? iv_sel : h_q;
            v_d    = h_d;
          end
        end
        ROUND: begin
          blk_d = {blk_q[479:0], w_new};
          v_d   = v_rnd;
          cnt_d = rnd_last ? '0 : cnt_q + 9'd1;
        end
        FINAL: begin
          for (int unsigned i = 0; i < 8; i++)
            h_d[32*i +: 32] = h_q[32*i +: 32] + v_q[32*i +: 32];
        end
        SHIFT_OUT: if (out_fire) cnt_d = out_last ? '0 : cnt_q + 9'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      blk_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      h_q    <= h_d;
      v_q    <= v_d;
      last_q <= last_d;
    end
  end

endmodule

// File: doc/sha256_serial_engine.md
SHA256_SERIAL_ENGINE -- requirements
Module: sha256_serial_engine

Interface
REQ-001 SHALL have parameter IN_W, default 8; input beat width in bits; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter OUT_W, default 8; digest beat width in bits; legal values 1, 2, 4, 8.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  input  1  global enable; 0 freezes all state and handshakes.
REQ-006 SHALL have ports in_valid input 1, in_data input IN_W, in_ready output 1; message beat handshake.
REQ-007 SHALL have ports first_blk input 1 and last_blk input 1; both sampled on the final beat of a block.
REQ-008 SHALL have ports out_valid output 1, out_data output OUT_W, out_ready input 1; digest beat handshake.
REQ-009 SHALL have port busy  output  1  high in every state except LOAD with zero beats taken.
REQ-010 SHALL have port mode224  input  1  selects SHA-224; sampled with first_blk.

Function
REQ-011 SHALL implement FSM states LOAD, ROUND, FINAL, SHIFT_OUT.
REQ-012 LOAD: SHALL assert in_ready, shift in_data MSB-first into a 512-bit block register on each cycle with in_valid, in_ready and ena high, and need 512/IN_W beats.
REQ-013 On the final LOAD beat, if first_blk=1, SHALL load H0..H7 with the SHA-256 IV, or SHA-224 IV when mode224=1 and the macro is defined.
REQ-014 LOAD to ROUND SHALL occur on the cycle after the final beat; in_ready SHALL be low outside LOAD.
REQ-015 ROUND SHALL run 64 rounds, one per enabled cycle, using a 16-word sliding message schedule and a K-constant ROM.
REQ-016 FINAL SHALL take one cycle and add working variables a..h into H0..H7 modulo 2^32.
REQ-017 After FINAL, last_blk=0 SHALL return to LOAD with H retained (chaining), and last_blk=1 SHALL enter SHIFT_OUT.
REQ-018 SHIFT_OUT SHALL present the digest MSB-first, OUT_W bits per beat: 256/OUT_W beats, or 224/OUT_W beats in SHA-224 mode.
REQ-019 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 After the last digest beat is accepted, SHALL return to LOAD; out_valid SHALL be 0 outside SHIFT_OUT.
REQ-021 Latency: final input beat accepted at cycle t gives FINAL at t+65, and for a last block, out_valid=1 at t+66 when ena is held high.
REQ-022 ena=0 SHALL stall every counter and register, with no beat accepted and no beat emitted.
REQ-023 first_blk=1 on a block SHALL override chaining even if the previous block had last_blk=0.

Reset
REQ-024 Asserting rst_n low in any state SHALL asynchronously force LOAD with the beat counter, round counter and block register cleared.
REQ-025 During reset, outputs SHALL be in_ready=1, out_valid=0, out_data=0, busy=0.
REQ-026 Reset SHALL clear H0..H7 to 0, so the next block needs first_blk=1.
REQ-027 Reset mid-operation SHALL abandon the operation; no partial digest is emitted.

Configuration
REQ-028 Macro SHA256_SERIAL_SHA224_EN SHALL compile in SHA-224 support: the mode224 IV select and a 224-bit truncated digest output.
REQ-029 Without the macro, mode224 SHALL be ignored, the output SHALL always be 256 bits, and no SHA-224 IV logic SHALL exist.

Structure
REQ-030 A shared package sha256_pkg SHALL hold the FSM state typedef, the IV constants (256 and 224), the K[0:63] table, and the Ch, Maj, Σ0, Σ1, σ0, σ1 functions.
REQ-031 One sub-module, sha256_round, SHALL hold the combinational single-round datapath (a..h, W, K in; a..h out).

Verification
REQ-032 Single padded block for "abc", first_blk=1, last_blk=1, IN_W=8 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-033 Padded empty message -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-034 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first_blk=1, last_blk=0, then first_blk=0, last_blk=1) -> digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-035 Macro defined, mode224=1, "abc" -> 28-byte digest 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, with out_valid dropping after 28 byte beats.
REQ-036 IN_W=1 and OUT_W=1 with random in_valid gaps, random out_ready stalls and ena toggling -> same "abc" digest, out_data stable across stalls, first out_valid exactly 66 enabled cycles after the last input beat.
REQ-037 rst_n pulsed low at round 30, then "abc" reloaded -> only the correct "abc" digest is emitted, and out_valid stays 0 during the aborted operation.
